// File: rtl/phys_reg_release_stage.sv
// Release stage feeding the physical-register free list: seeds it with unmapped
// registers after reset, then stages up to two retire releases per cycle.
module phys_reg_release_stage #(
   parameter int NUM_PHYS_REGS = 64,
   parameter int NUM_ARCH_REGS = 32,
   parameter int QUEUE_DEPTH   = 4,
   localparam int PHYS_ADDR_W  = $clog2(NUM_PHYS_REGS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  release_valid,
   input  logic [1:0][PHYS_ADDR_W-1:0] release_phys_addr,
   output logic                        release_ready,
   input  logic                        free_list_full,
   input  logic                        free_list_pop,
   output logic                        free_list_push,
   output logic                        free_list_potential_push,
   output logic [PHYS_ADDR_W-1:0]      free_list_data_in,
   output logic                        init_done
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                 state_r;
   logic [PHYS_ADDR_W-1:0] init_addr_r;
   logic [PHYS_ADDR_W-1:0] queue_r [QUEUE_DEPTH];
   logic [PTR_W-1:0]       head_r;
   logic [PTR_W-1:0]       tail_r;
   logic [CNT_W-1:0]       count_r;

   logic                   pot_s;
   logic [PHYS_ADDR_W-1:0] data_s;
   logic                   push_s;
   logic                   drain_s;
   logic                   ready_s;
   logic                   acc0_s;
   logic                   acc1_s;
   logic [1:0]             num_acc_s;
   logic [CNT_W-1:0]       count_next_s;

   // Candidate push source: seed counter during INIT, queue head during RUN.
   always_comb begin
      pot_s  = 1'b0;
      data_s = '0;
      case (state_r)
         INIT: begin
            pot_s  = 1'b1;
            data_s = init_addr_r;
         end
         RUN: begin
            pot_s  = (count_r != '0);
            data_s = queue_r[head_r];
         end
         default: begin
            pot_s  = 1'b0;
            data_s = '0;
         end
      endcase
   end

   // Handshake, accept and occupancy bookkeeping; x0 releases are never queued.
   always_comb begin
      push_s       = rst & pot_s & (~free_list_full | free_list_pop);
      drain_s      = push_s & (state_r == RUN);
      // Registered count only: a same-cycle drain does not earn extra credit.
      ready_s      = rst & (state_r == RUN) &
                     ((CNT_W'(QUEUE_DEPTH) - count_r) >= CNT_W'(2));
      acc0_s       = release_valid[0] & ready_s & (release_phys_addr[0] != '0);
      acc1_s       = release_valid[1] & ready_s & (release_phys_addr[1] != '0);
      num_acc_s    = {1'b0, acc0_s} + {1'b0, acc1_s};
      count_next_s = count_r + CNT_W'(num_acc_s) - CNT_W'(drain_s);
   end

   // Outputs are held low while reset is asserted.
   always_comb begin
      release_ready            = ready_s;
      free_list_push           = push_s;
      free_list_potential_push = rst & pot_s;
      free_list_data_in        = rst ? data_s : '0;
      init_done                = rst & (state_r == RUN);
   end

   // Control state: seeding counter, FSM and queue pointers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= INIT;
         init_addr_r <= PHYS_ADDR_W'(NUM_ARCH_REGS);
         head_r      <= '0;
         tail_r      <= '0;
         count_r     <= '0;
      end else begin
         case (state_r)
            INIT: begin
               if (push_s) begin
                  init_addr_r <= init_addr_r + PHYS_ADDR_W'(1);
                  if (init_addr_r == PHYS_ADDR_W'(NUM_PHYS_REGS - 1)) begin
                     state_r <= RUN;
                  end else begin
                     state_r <= INIT;
                  end
               end else begin
                  state_r <= INIT;
               end
            end
            RUN: begin
               state_r <= RUN;
            end
            default: begin
               state_r <= INIT;
            end
         endcase
         if (drain_s) begin
            head_r <= head_r + PTR_W'(1);
         end else begin
            head_r <= head_r;
         end
         tail_r  <= tail_r + PTR_W'(num_acc_s);
         count_r <= count_next_s;
      end
   end

   // Queue storage; port 1 lands behind port 0 when both are accepted.
   always_ff @(posedge clk) begin
      if (acc0_s) begin
         queue_r[tail_r] <= release_phys_addr[0];
      end
      if (acc1_s) begin
         queue_r[tail_r + PTR_W'(acc0_s)] <= release_phys_addr[1];
      end
   end

   // Interface and occupancy invariants.
   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
      !(free_list_push && free_list_full && !free_list_pop));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      count_next_s <= CNT_W'(QUEUE_DEPTH));
   a_release_protocol: assert property (@(posedge clk) disable iff (!rst)
      (release_valid != 2'b00) |-> release_ready);

endmodule

// File: tb/tb_phys_reg_release_stage.sv
// Scoreboard bench: the driver appends expected free-list pushes to a queue,
// the monitor pops and compares whenever the stage pushes.
module tb_phys_reg_release_stage;
   localparam int NP = 64;
   localparam int NA = 32;
   localparam int QD = 4;
   localparam int AW = 6;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [1:0]         release_valid = 2'b00;
   logic [1:0][AW-1:0] release_phys_addr = '0;
   logic               release_ready;
   logic               free_list_full = 1'b0;
   logic               free_list_pop = 1'b0;
   logic               free_list_push;
   logic               free_list_potential_push;
   logic [AW-1:0]      free_list_data_in;
   logic               init_done;

   phys_reg_release_stage #(.NUM_PHYS_REGS(NP), .NUM_ARCH_REGS(NA), .QUEUE_DEPTH(QD)) dut (
      .clk(clk), .rst(rst),
      .release_valid(release_valid), .release_phys_addr(release_phys_addr),
      .release_ready(release_ready),
      .free_list_full(free_list_full), .free_list_pop(free_list_pop),
      .free_list_push(free_list_push),
      .free_list_potential_push(free_list_potential_push),
      .free_list_data_in(free_list_data_in),
      .init_done(init_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: every address the free list should receive, in order.
   logic [AW-1:0] expq[$];
   int  seed_left;
   bit  m_run;
   bit  m_ready;
   int  m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      expq.delete();
      for (int a = NA; a < NP; a++) expq.push_back(AW'(a));
      seed_left = NP - NA;
   endtask

   // Monitor: registered outputs checked at posedge+1, push/data at negedge.
   initial begin
      bit exp_pot;
      bit exp_push;
      model_reset();
      m_run = 1'b0; m_ready = 1'b0; m_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            model_reset();
            m_run = 1'b0; m_ready = 1'b0; m_cnt = 0;
         end else begin
            m_run   = (seed_left == 0);
            m_cnt   = m_run ? expq.size() : 0;
            m_ready = m_run && (m_cnt <= QD - 2);
         end
         chk("release_ready", {31'd0, release_ready}, {31'd0, m_ready});
         chk("init_done", {31'd0, init_done}, {31'd0, m_run});
         @(negedge clk);
         if (!rst) begin
            chk("reset_outputs", {22'd0, free_list_push, free_list_potential_push,
                free_list_data_in, release_ready, init_done}, 32'd0);
         end else begin
            exp_pot  = m_run ? (m_cnt != 0) : 1'b1;
            exp_push = exp_pot && (!free_list_full || free_list_pop);
            chk("potential_push", {31'd0, free_list_potential_push}, {31'd0, exp_pot});
            chk("push", {31'd0, free_list_push}, {31'd0, exp_push});
            if (exp_pot && expq.size() > 0)
               chk("data_in", {26'd0, free_list_data_in}, {26'd0, expq[0]});
            if (exp_push && expq.size() > 0) begin
               void'(expq.pop_front());
               if (seed_left > 0) seed_left--;
            end
         end
      end
   end

   // One cycle of stimulus; releases are only offered when the model says ready.
   task automatic drive(input logic r, input logic full, input logic pop,
                        input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      @(posedge clk);
      #2;
      if (!r || !m_ready) v = 2'b00;
      rst               = r;
      free_list_full    = full;
      free_list_pop     = pop;
      release_valid     = v;
      release_phys_addr = {a1, a0};
      if (v[0] && a0 != '0) expq.push_back(a0);
      if (v[1] && a1 != '0) expq.push_back(a1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      return (($urandom_range(0, 5) == 0) ? AW'(0) : AW'($urandom_range(1, NP - 1)));
   endfunction

   task automatic random_run(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b1, ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), rand_addr(), rand_addr());
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
      drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
      // Seeding with a stall while address 40 is offered.
      idle(8);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 2'b00, '0, '0);
      idle(30);
      // Dual release, then x0 filtering.
      drive(1'b1, 1'b0, 1'b0, 2'b11, AW'(7), AW'(45));
      idle(4);
      drive(1'b1, 1'b0, 1'b0, 2'b11, AW'(0), AW'(12));
      idle(4);
      // Fill the queue behind a full free list, then release with a pop.
      drive(1'b1, 1'b1, 1'b0, 2'b11, AW'(3), AW'(4));
      drive(1'b1, 1'b1, 1'b0, 2'b11, AW'(5), AW'(6));
      drive(1'b1, 1'b1, 1'b0, 2'b00, '0, '0);
      drive(1'b1, 1'b1, 1'b1, 2'b00, '0, '0);
      idle(6);
      random_run(1500);
      // Reset mid-run with entries queued, then re-seed.
      drive(1'b1, 1'b1, 1'b0, 2'b11, AW'(9), AW'(10));
      drive(1'b1, 1'b1, 1'b0, 2'b01, AW'(11), AW'(0));
      drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
      idle(40);
      random_run(1000);
      for (int i = 0; i < 20 && expq.size() > 0; i++) idle(1);
      @(negedge clk);
      chk("drained", expq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
